// File: rtl/mem_cache_ctrl.sv
// Multi-channel line prefetcher: one shared SRAM read port is granted
// round-robin to per-channel FWFT FIFOs under a credit check.
module mem_cache_ctrl #(
    parameter int CACHE_WIDTH = 162,
    parameter int NUM_CH      = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_WIDTH  = 12,
    parameter int LEN_WIDTH   = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clk_en,
    input  logic                          start,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]  base_addr,
    input  logic [NUM_CH*LEN_WIDTH-1:0]   line_cnt,
    input  logic [NUM_CH-1:0]             read_req,
    output logic [NUM_CH*CACHE_WIDTH-1:0] cache_out,
    output logic [NUM_CH-1:0]             empty,
    output logic                          sram_rd_en,
    output logic [ADDR_WIDTH-1:0]         sram_addr,
    input  logic [CACHE_WIDTH-1:0]        sram_rd_data,
    output logic                          busy,
    output logic                          done
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]  base_q   [NUM_CH];
    logic [ADDR_WIDTH-1:0]  offset_q [NUM_CH];
    logic [LEN_WIDTH-1:0]   remain_q [NUM_CH];
    logic [CACHE_WIDTH-1:0] mem      [NUM_CH][FIFO_DEPTH];
    logic [PW-1:0]          rd_ptr   [NUM_CH];
    logic [PW-1:0]          wr_ptr   [NUM_CH];
    logic [CNTW-1:0]        count    [NUM_CH];

    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     grant_idx;
    logic              grant;
    logic              ret_valid;
    logic [CW-1:0]     ret_tag;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic              all_zero;

    // push doubles as the in-flight credit of the channel being returned
    always_comb begin
        push     = '0;
        pop      = '0;
        eligible = '0;
        all_zero = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            push[i] = ret_valid && (ret_tag == CW'(i));
            pop[i]  = clk_en && read_req[i] && (count[i] != '0);
            if (remain_q[i] != '0)
                all_zero = 1'b0;
            eligible[i] = (remain_q[i] != '0) &&
                ((count[i] + CNTW'(push[i])) < CNTW'(FIFO_DEPTH));
        end
    end

    always_comb begin
        int idx;
        idx       = 0;
        grant     = 1'b0;
        grant_idx = '0;
        if (state == FETCH && clk_en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_CH;
                if (!grant && eligible[idx]) begin
                    grant     = 1'b1;
                    grant_idx = CW'(idx);
                end
            end
        end
    end

    always_comb begin
        sram_rd_en = grant;
        sram_addr  = '0;
        if (grant)
            sram_addr = base_q[grant_idx] + offset_q[grant_idx];
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        if (clk_en) begin
            case (state)
                IDLE: begin
                    if (start)
                        state_nxt = FETCH;
                end
                FETCH: begin
                    if (all_zero)
                        state_nxt = DRAIN;
                end
                DRAIN: begin
                    if (!ret_valid) begin
                        state_nxt = IDLE;
                        done      = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    // return pipeline runs regardless of clk_en so a granted line is never lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            ret_valid <= 1'b0;
            ret_tag   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                base_q[i]   <= '0;
                offset_q[i] <= '0;
                remain_q[i] <= '0;
                rd_ptr[i]   <= '0;
                wr_ptr[i]   <= '0;
                count[i]    <= '0;
            end
        end else begin
            ret_valid <= grant;
            ret_tag   <= grant_idx;
            if (clk_en) begin
                state <= state_nxt;
                if (grant)
                    rr_ptr <= (int'(grant_idx) == NUM_CH - 1) ?
                              '0 : grant_idx + 1'b1;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (state == IDLE && clk_en && start) begin
                    base_q[i]   <= base_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    offset_q[i] <= '0;
                    remain_q[i] <= line_cnt[i*LEN_WIDTH +: LEN_WIDTH];
                end else if (grant && grant_idx == CW'(i)) begin
                    offset_q[i] <= offset_q[i] + 1'b1;
                    remain_q[i] <= remain_q[i] - 1'b1;
                end
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + CNTW'(push[i]) - CNTW'(pop[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i])
                mem[i][wr_ptr[i]] <= sram_rd_data;
        end
    end

    always_comb begin
        cache_out = '0;
        empty     = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            empty[i] = (count[i] == '0);
            if (count[i] != '0)
                cache_out[i*CACHE_WIDTH +: CACHE_WIDTH] = mem[i][rd_ptr[i]];
        end
    end

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// Bench for mem_cache_ctrl: queue-based reference model compared every
// cycle, directed scenarios with literal address traces, random traffic.
module tb_mem_cache_ctrl;

    localparam int NC = 2;
    localparam int W  = 162;
    localparam int D  = 4;
    localparam int AW = 12;
    localparam int LW = 12;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_DRAIN = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clk_en = 1'b1;
    logic           start = 1'b0;
    logic [NC*AW-1:0] base_addr = '0;
    logic [NC*LW-1:0] line_cnt = '0;
    logic [NC-1:0]  read_req = '0;
    logic [NC*W-1:0] cache_out;
    logic [NC-1:0]  empty;
    logic           sram_rd_en;
    logic [AW-1:0]  sram_addr;
    logic [W-1:0]   sram_rd_data = '0;
    logic           busy;
    logic           done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int trace[$];

    // reference model state
    int ph;
    int rr;
    int base_m [NC];
    int off_m  [NC];
    int rem_m  [NC];
    logic [W-1:0] q [NC][$];
    bit pend_v;
    int pend_ch;
    int pend_addr;

    mem_cache_ctrl #(
        .CACHE_WIDTH(W),
        .NUM_CH(NC),
        .FIFO_DEPTH(D),
        .ADDR_WIDTH(AW),
        .LEN_WIDTH(LW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clk_en(clk_en),
        .start(start),
        .base_addr(base_addr),
        .line_cnt(line_cnt),
        .read_req(read_req),
        .cache_out(cache_out),
        .empty(empty),
        .sram_rd_en(sram_rd_en),
        .sram_addr(sram_addr),
        .sram_rd_data(sram_rd_data),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] line_of(input int a);
        logic [W-1:0] v;
        v = '0;
        for (int j = 0; j < 13; j++)
            v[j*12 +: 12] = 12'(a * (j + 3) + j * 77);
        v[W-1 -: 6] = 6'(a ^ 42);
        return v;
    endfunction

    // SRAM: data one cycle after the strobe, garbage otherwise
    always @(posedge clk) begin
        if (sram_rd_en)
            sram_rd_data <= line_of(int'(sram_addr));
        else
            sram_rd_data <= ~sram_rd_data;
    end

    task automatic check(input string nm, input logic [255:0] act,
                         input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        ph = P_IDLE;
        rr = 0;
        pend_v = 1'b0;
        pend_ch = 0;
        pend_addr = 0;
        for (int i = 0; i < NC; i++) begin
            base_m[i] = 0;
            off_m[i] = 0;
            rem_m[i] = 0;
            q[i].delete();
        end
    endtask

    function automatic int pick();
        int c;
        if (ph != P_FETCH || !clk_en)
            return -1;
        for (int k = 0; k < NC; k++) begin
            c = (rr + k) % NC;
            if (rem_m[c] > 0 &&
                q[c].size() + ((pend_v && pend_ch == c) ? 1 : 0) < D)
                return c;
        end
        return -1;
    endfunction

    task automatic model_step();
        int g;
        bit all0;
        bit was_pend;
        g = pick();
        all0 = 1'b1;
        for (int i = 0; i < NC; i++)
            if (rem_m[i] != 0)
                all0 = 1'b0;
        for (int i = 0; i < NC; i++)
            if (clk_en && read_req[i] && q[i].size() != 0)
                void'(q[i].pop_front());
        was_pend = pend_v;
        if (pend_v)
            q[pend_ch].push_back(line_of(pend_addr));
        pend_v = (g >= 0);
        if (g >= 0) begin
            pend_ch = g;
            pend_addr = (base_m[g] + off_m[g]) % 4096;
            off_m[g]++;
            rem_m[g]--;
            rr = (g + 1) % NC;
        end
        if (clk_en) begin
            if (ph == P_IDLE && start) begin
                for (int i = 0; i < NC; i++) begin
                    base_m[i] = int'(base_addr[i*AW +: AW]);
                    rem_m[i] = int'(line_cnt[i*LW +: LW]);
                    off_m[i] = 0;
                end
                ph = P_FETCH;
            end else if (ph == P_FETCH && all0) begin
                ph = P_DRAIN;
            end else if (ph == P_DRAIN && !was_pend) begin
                ph = P_IDLE;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            model_reset();
        else
            model_step();
    end

    always @(negedge clk) begin
        int g;
        logic [AW-1:0] ea;
        if (!rst_n)
            model_reset();
        g = pick();
        ea = '0;
        if (g >= 0)
            ea = AW'((base_m[g] + off_m[g]) % 4096);
        check("sram_rd_en", 256'(sram_rd_en), 256'(g >= 0));
        check("sram_addr", 256'(sram_addr), 256'(ea));
        check("busy", 256'(busy), 256'(ph != P_IDLE));
        check("done", 256'(done),
              256'(ph == P_DRAIN && !pend_v && clk_en));
        for (int i = 0; i < NC; i++) begin
            check($sformatf("empty%0d", i), 256'(empty[i]),
                  256'(q[i].size() == 0));
            check($sformatf("cache_out%0d", i),
                  256'(cache_out[i*W +: W]),
                  256'((q[i].size() != 0) ? q[i][0] : W'(0)));
        end
        if (done)
            done_cnt++;
        if (sram_rd_en)
            trace.push_back(int'(sram_addr));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic kick(input int b0, input int c0, input int b1, input int c1);
        step();
        base_addr = {AW'(b1), AW'(b0)};
        line_cnt = {LW'(c1), LW'(c0)};
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++)
            step();
        check(nm, 256'(done_cnt - d0), 256'(1));
    endtask

    task automatic check_trace(input string nm, input int exp[$]);
        check({nm, "_len"}, 256'(trace.size()), 256'(exp.size()));
        for (int k = 0; k < exp.size() && k < trace.size(); k++)
            check(nm, 256'(trace[k]), 256'(exp[k]));
    endtask

    initial begin
        int exp[$];
        int d0;
        int n0;
        model_reset();
        read_req = '1;
        #30 rst_n = 1'b1;

        // idle after reset, pops on empty ignored
        run(500);
        check("idle_empty", 256'(empty), 256'(2'b11));
        check("idle_reads", 256'(trace.size()), 256'(0));
        check("idle_done", 256'(done_cnt), 256'(0));

        // back-pressure, round-robin alternation
        read_req = '0;
        trace.delete();
        kick('h100, 8, 'h200, 8);
        run(30);
        exp.delete();
        for (int k = 0; k < 8; k++)
            exp.push_back((k % 2 != 0) ? 'h200 + k / 2 : 'h100 + k / 2);
        check_trace("bp_order", exp);
        check("bp_busy", 256'(busy), 256'(1));
        check("bp_port_idle", 256'(sram_rd_en), 256'(0));
        trace.delete();
        read_req = 2'b01;
        run(30);
        exp.delete();
        exp = {'h104, 'h105, 'h106, 'h107};
        check_trace("bp_ch0_only", exp);
        read_req = 2'b11;
        wait_done("bp_done", 100);

        // single channel fetch
        run(5);
        trace.delete();
        read_req = 2'b01;
        kick('h010, 3, 0, 0);
        wait_done("single_done", 50);
        exp.delete();
        exp = {'h010, 'h011, 'h012};
        check_trace("single", exp);

        // address wrap
        run(5);
        trace.delete();
        read_req = 2'b11;
        kick('hFFE, 4, 'h050, 0);
        wait_done("wrap_done", 50);
        exp.delete();
        exp = {'hFFE, 'hFFF, 'h000, 'h001};
        check_trace("wrap", exp);

        // all-zero counts
        run(3);
        trace.delete();
        kick(0, 0, 0, 0);
        wait_done("zero_done", 4);
        check("zero_reads", 256'(trace.size()), 256'(0));

        // start while busy is ignored
        run(3);
        trace.delete();
        read_req = '0;
        kick('h400, 6, 0, 0);
        run(2);
        kick('h700, 3, 'h710, 3);
        read_req = 2'b11;
        wait_done("busy_start_done", 80);
        run(20);
        exp.delete();
        for (int k = 0; k < 6; k++)
            exp.push_back('h400 + k);
        check_trace("busy_start", exp);

        // clk_en dropped right after a grant
        run(3);
        trace.delete();
        read_req = '0;
        kick('h300, 6, 0, 0);
        for (int i = 0; i < 10 && !sram_rd_en; i++)
            step();
        step();
        clk_en = 1'b0;
        read_req = 2'b01;
        n0 = trace.size();
        run(6);
        check("gate_no_grant", 256'(trace.size()), 256'(n0));
        check("gate_line_kept", 256'(empty[0]), 256'(0));
        clk_en = 1'b1;
        wait_done("gate_done", 80);
        check("gate_lines", 256'(trace.size()), 256'(6));

        // async reset mid-fetch
        run(3);
        read_req = '0;
        kick('h500, 8, 'h600, 8);
        run(3);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_rd_en", 256'(sram_rd_en), 256'(0));
        check("rst_addr", 256'(sram_addr), 256'(0));
        check("rst_empty", 256'(empty), 256'(2'b11));
        check("rst_cache_out", 256'(cache_out), 256'(0));
        run(3);
        rst_n = 1'b1;
        run(20);
        check("rst_no_done", 256'(done_cnt - d0), 256'(0));
        read_req = 2'b11;
        trace.delete();
        kick('h020, 2, 'h030, 2);
        wait_done("after_rst_done", 60);
        exp.delete();
        exp = {'h020, 'h030, 'h021, 'h031};
        check_trace("after_rst", exp);

        // random traffic
        for (int t = 0; t < 40; t++) begin
            int dr;
            clk_en = 1'b1;
            kick(int'($urandom_range(0, 4095)), int'($urandom_range(0, 9)),
                 int'($urandom_range(0, 4095)), int'($urandom_range(0, 9)));
            dr = done_cnt;
            for (int c = 0; c < 400 && done_cnt == dr; c++) begin
                read_req = NC'($urandom);
                clk_en = ($urandom_range(0, 7) != 0);
                start = ($urandom_range(0, 15) == 0);
                step();
            end
            start = 1'b0;
            clk_en = 1'b1;
            check("rand_done", 256'(done_cnt > dr), 256'(1));
        end
        read_req = 2'b11;
        run(80);
        check("final_empty", 256'(empty), 256'(2'b11));
        check("final_idle", 256'(busy), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_cache_ctrl.md
Name: mem_cache_ctrl

Overview:
- Multi-channel line prefetcher between the on-chip line SRAM and the PE array caches.
- Generalises the two-pair (02/13) single-stream cache controller to NUM_CH independent channels.
- Adds a programmable base address and line count per channel, and per-channel FWFT FIFOs of parametrised depth.
- Adds round-robin arbitration of one shared SRAM read port, plus busy/done status.

Parameters:
- CACHE_WIDTH, 162, bits per cache line.
- NUM_CH, 2, number of consumer channels (1..8).
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, at least 2.
- ADDR_WIDTH, 12, SRAM line-address width.
- LEN_WIDTH, 12, width of the per-channel line count.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- clk_en, in, 1, global enable; 0 freezes all state except the SRAM return write.
- start, in, 1, single-cycle pulse; latches base_addr and line_cnt; ignored while busy=1.
- base_addr, in, NUM_CH*ADDR_WIDTH, per-channel start line address; channel i occupies slice i.
- line_cnt, in, NUM_CH*LEN_WIDTH, per-channel number of lines to fetch.
- read_req, in, NUM_CH, per-channel pop request.
- cache_out, out, NUM_CH*CACHE_WIDTH, per-channel FIFO head (FWFT); valid while empty[i]=0.
- empty, out, NUM_CH, per-channel FIFO empty flag.
- sram_rd_en, out, 1, SRAM read strobe.
- sram_addr, out, ADDR_WIDTH, SRAM read address.
- sram_rd_data, in, CACHE_WIDTH, read data, valid exactly one cycle after sram_rd_en.
- busy, out, 1, fetch in progress.
- done, out, 1, one-cycle pulse when all channels have been fetched.

Behaviour:
- Reset: FIFOs emptied, empty=all 1s, cache_out=0, sram_rd_en=0, sram_addr=0, busy=0, done=0, RR pointer=0, return pipeline cleared. Reset mid-fetch aborts with no done pulse.
- FSM IDLE -> FETCH on start (clk_en=1). FETCH -> DRAIN when all remaining counts are 0. DRAIN -> IDLE when no read is in flight; done=1 for that one cycle. busy=1 in FETCH and DRAIN.
- Eligibility: channel i is eligible when remaining[i]>0 and count[i]+inflight[i] < FIFO_DEPTH (credit check, so no overflow is possible).
- Grant: the first eligible channel at or after the RR pointer. The pointer moves to grant+1 mod NUM_CH. At most one grant per cycle.
- Grant outputs: sram_rd_en=1, sram_addr = base[i]+offset[i] mod 2^ADDR_WIDTH (wraps silently). offset[i] increments and remaining[i] decrements.
- Latency: start sampled at edge k -> sram_rd_en high in cycle k+1 -> data written at edge k+2 -> empty[i]=0 and line on cache_out from cycle k+2.
- Return pipeline: a channel tag is registered alongside sram_rd_en. The return write into FIFO[tag] always completes, even if clk_en fell meanwhile, so no data is lost.
- clk_en=0: no grants, no pops, all counters, pointers and FSM frozen.
- Pop: read_req[i] with empty[i]=0 and clk_en=1 advances the head; cache_out[i] shows the next entry in the same cycle after the edge. read_req[i] on empty is ignored (no underflow, no state change).
- Same-cycle push and pop on one channel: count unchanged, both take effect.
- Zero-length channels: line_cnt[i]=0 is never granted. All-zero counts give done at edge k+1 (FETCH -> DRAIN -> IDLE without any sram_rd_en).
- Lines within a channel appear in address order. Channels are independent; a stalled consumer blocks only its own channel.

Test Plan:
- Reset then idle: rst_n low 30 ns, then 5 us with no start -> empty=2'b11, sram_rd_en never 1, done never 1.
- Single-channel fetch: NUM_CH=2, base0=0x010, cnt0=3, cnt1=0, read_req0 held 1 -> addresses 0x010, 0x011, 0x012 issued; cache_out0 shows the three lines in order; one done pulse.
- Back-pressure: cnt0=cnt1=8, read_req held 0 -> exactly 4 reads per channel, issued alternating ch0/ch1 (RR order), then sram_rd_en=0 with busy=1. Releasing read_req0 -> only ch0 resumes.
- Wrap and boundaries: base0=0xFFE, cnt0=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001. read_req on empty -> no change. start while busy -> ignored.
- clk_en gating: clk_en dropped in the cycle sram_rd_en=1 -> the returning line is still written; no further grants or pops until clk_en=1; final line count is unchanged.
- Async reset mid-fetch: rst_n asserted in FETCH -> all outputs return to reset values immediately, no done pulse; a new start afterwards completes normally.
